// File: rtl/usb_rx_rcu.sv
// Receive control unit for the USB 1.1 full-speed receiver: sequences one packet
// through SYNC/PID checks, byte storage and end-of-packet, with Moore-decoded outputs.
module usb_rx_rcu #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_d_edge,
    input  logic       i_eop,
    input  logic       i_shift_enable,
    input  logic       i_byte_received,
    input  logic [7:0] i_rcv_data,
    output logic       o_rcving,
    output logic       o_w_enable,
    output logic       o_r_error,
    output logic       o_pkt_done,
    output logic [6:0] o_byte_cnt
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE, WAIT_SYNC, CHECK_SYNC, WAIT_PID, CHECK_PID, STORE,
        RCV_BYTE, DONE, EOP_WAIT, ERR_EOP, ERR_IDLE
    } state_t;

    state_t     r_state, w_next;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_byte_cnt;
    logic       w_enter_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (i_d_edge) w_next = WAIT_SYNC;
            WAIT_SYNC:  if (i_byte_received) w_next = CHECK_SYNC;
                        else if (i_eop)      w_next = ERR_EOP;
            CHECK_SYNC: w_next = (i_rcv_data == SYNC_BYTE) ? WAIT_PID : ERR_EOP;
            WAIT_PID:   if (i_byte_received) w_next = CHECK_PID;
                        else if (i_eop)      w_next = ERR_EOP;
            CHECK_PID:  w_next = (i_rcv_data[7:4] == ~i_rcv_data[3:0]) ? STORE : ERR_EOP;
            STORE:      w_next = RCV_BYTE;
            RCV_BYTE:   if (i_byte_received)
                            w_next = (r_byte_cnt < MAX_CNT) ? STORE : ERR_EOP;
                        // SE0 mid-byte means a truncated byte, not a clean end
                        else if (i_eop)
                            w_next = (r_bit_cnt == 3'd0) ? DONE : ERR_EOP;
            DONE:       w_next = EOP_WAIT;
            EOP_WAIT:   if (!i_eop) w_next = IDLE;
            ERR_EOP:    if (!i_eop) w_next = ERR_IDLE;
            ERR_IDLE:   if (i_d_edge) w_next = WAIT_SYNC;
            default:    w_next = IDLE;
        endcase
    end

    assign w_enter_sync = (w_next == WAIT_SYNC) && (r_state != WAIT_SYNC);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_byte_received || w_enter_sync)
            r_bit_cnt <= 3'd0;
        else if (r_state == RCV_BYTE && i_shift_enable && !i_eop)
            r_bit_cnt <= r_bit_cnt + 3'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_enter_sync) r_byte_cnt <= 7'd0;
        else if (r_state == STORE) r_byte_cnt <= r_byte_cnt + 7'd1;
    end

    assign o_rcving   = (r_state != IDLE) && (r_state != ERR_IDLE);
    assign o_r_error  = (r_state == ERR_EOP) || (r_state == ERR_IDLE);
    assign o_w_enable = (r_state == STORE);
    assign o_pkt_done = (r_state == DONE);
    assign o_byte_cnt = r_byte_cnt;

endmodule
